// File: rtl/poker_pkg.sv
// Shared rank constants, scanner state encoding and rank-to-bitmap mapping.
package poker_pkg;

  localparam int RANK_W    = 4;
  localparam int NUM_RANKS = 13;

  localparam logic [RANK_W-1:0] ACE_RANK = 4'd13;
  localparam logic [RANK_W-1:0] MIN_RANK = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } scan_state_e;

  // Bitmap bit for a rank; rank 0 aliases the ace so the wheel step reuses its bit.
  function automatic logic [RANK_W-1:0] rank_index(input logic [RANK_W-1:0] rank);
    if (rank == 4'd0) begin
      return 4'd12;
    end else begin
      return rank - 4'd1;
    end
  endfunction

endpackage

// File: rtl/straight_run_scan.sv
// Consecutive-rank run counter; flags the step at which the run reaches RUN_LEN.
module straight_run_scan
  import poker_pkg::*;
#(
  parameter int RUN_LEN = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_step,
  input  logic i_bit,
  output logic o_match
);

  localparam logic [RANK_W-1:0] RUN_TGT = RANK_W'(RUN_LEN);

  logic [RANK_W-1:0] r_run;
  logic [RANK_W-1:0] w_run_next;

  // Next run length and completion flag for the rank under examination.
  always_comb begin
    w_run_next = 4'd0;
    if (i_bit) begin
      w_run_next = r_run + 4'd1;
    end else begin
      w_run_next = 4'd0;
    end
    o_match = i_step && (w_run_next == RUN_TGT);
  end

  // Run length register, restarted for every new hand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 4'd0;
    end else if (i_clear) begin
      r_run <= 4'd0;
    end else if (i_step) begin
      r_run <= w_run_next;
    end
  end

endmodule

// File: rtl/straight_scanner.sv
// Loads a hand into a rank bitmap, then scans ace-down for the highest straight.
// Optional macro STRAIGHT_WHEEL_EN adds an ace-low (rank 0) scan step.
module straight_scanner
  import poker_pkg::*;
#(
  parameter int NUM_CARDS = 7,
  parameter int RUN_LEN   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              card_valid,
  input  logic [RANK_W-1:0] card_number,
  output logic              busy,
  output logic              done,
  output logic              is_straight,
  output logic [RANK_W-1:0] max_num,
  output logic              bad_card
);

  localparam int                CNT_W     = $clog2(NUM_CARDS + 1);
  localparam logic [CNT_W-1:0]  LAST_CARD = CNT_W'(NUM_CARDS - 1);
  localparam logic [RANK_W-1:0] RUN_OFS   = RANK_W'(RUN_LEN - 1);
`ifdef STRAIGHT_WHEEL_EN
  localparam logic [RANK_W-1:0] LAST_RANK = 4'd0;
`else
  localparam logic [RANK_W-1:0] LAST_RANK = MIN_RANK;
`endif

  scan_state_e          r_state;
  logic [NUM_RANKS-1:0] r_bitmap;
  logic [CNT_W-1:0]     r_count;
  logic [RANK_W-1:0]    r_rank;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_is;
  logic [RANK_W-1:0]    r_max;
  logic                 r_bad;

  logic              w_accept_start;
  logic              w_step;
  logic              w_scan_bit;
  logic              w_card_bad;
  logic [RANK_W-1:0] w_load_idx;
  logic              w_match;

  // Start qualification, card decode and the bitmap bit under scan.
  always_comb begin
    w_accept_start = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_step         = (r_state == ST_SCAN);
    w_card_bad     = (card_number > ACE_RANK);
    w_load_idx     = rank_index(card_number);
    w_scan_bit     = r_bitmap[rank_index(r_rank)];
  end

  straight_run_scan #(
    .RUN_LEN (RUN_LEN)
  ) u_run_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept_start),
    .i_step  (w_step),
    .i_bit   (w_scan_bit),
    .o_match (w_match)
  );

  // Hand FSM with loader, scan pointer and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_bitmap <= {NUM_RANKS{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_rank   <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_is     <= 1'b0;
      r_max    <= 4'd0;
      r_bad    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= ST_LOAD;
            r_busy   <= 1'b1;
            r_bitmap <= {NUM_RANKS{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_rank   <= ACE_RANK;
            r_is     <= 1'b0;
            r_max    <= 4'd0;
            r_bad    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (card_valid) begin
            if (w_card_bad) begin
              r_bad <= 1'b1;
            end else begin
              r_bitmap[w_load_idx] <= 1'b1;
            end
            r_count <= r_count + CNT_W'(1);
            if (r_count == LAST_CARD) begin
              r_state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (w_match) begin
            r_is    <= 1'b1;
            r_max   <= r_rank + RUN_OFS;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_rank == LAST_RANK) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_rank <= r_rank - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign is_straight = r_is;
  assign max_num     = r_max;
  assign bad_card    = r_bad;

endmodule

// File: tb/tb_straight_scanner.sv
// Randomized and directed bench for straight_scanner against a rank-window reference model.
module tb_straight_scanner;

`ifdef STRAIGHT_WHEEL_EN
  localparam int WHEEL = 1;
`else
  localparam int WHEEL = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_start, a_valid, a_busy, a_done, a_is, a_bad;
  logic [3:0] a_card, a_max;
  logic       b_start, b_valid, b_busy, b_done, b_is, b_bad;
  logic [3:0] b_card, b_max;

  straight_scanner u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .card_valid(a_valid), .card_number(a_card),
    .busy(a_busy), .done(a_done), .is_straight(a_is), .max_num(a_max), .bad_card(a_bad)
  );

  straight_scanner #(.NUM_CARDS(5), .RUN_LEN(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .card_valid(b_valid), .card_number(b_card),
    .busy(b_busy), .done(b_done), .is_straight(b_is), .max_num(b_max), .bad_card(b_bad)
  );

  int checks = 0;
  int fails  = 0;

  logic [3:0] hand[$];
  int         gaps[$];

  logic       cur_busy, cur_done, cur_is, cur_bad;
  logic [3:0] cur_max;

  int         obs_lat;
  bit         obs_timeout;
  logic       obs_busy_load, obs_busy_done, obs_is, obs_bad, obs_done_next, obs_is_next;
  logic [3:0] obs_max, obs_max_next;

  bit exp_is, exp_bad;
  int exp_max, exp_scan;

  task automatic set_in(input bit sel, input logic st, input logic v, input logic [3:0] c);
    if (sel) begin b_start = st; b_valid = v; b_card = c; end
    else begin a_start = st; a_valid = v; a_card = c; end
  endtask

  task automatic sample(input bit sel);
    if (sel) begin cur_busy = b_busy; cur_done = b_done; cur_is = b_is; cur_max = b_max; cur_bad = b_bad; end
    else begin cur_busy = a_busy; cur_done = a_done; cur_is = a_is; cur_max = a_max; cur_bad = a_bad; end
  endtask

  // Plays hand[] with gaps[] into one DUT, optionally waving start while busy.
  task automatic play(input bit sel, input bit poke);
    set_in(sel, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    set_in(sel, 1'b0, 1'b0, 4'd0);
    sample(sel);
    obs_busy_load = cur_busy;
    obs_lat = 0;
    foreach (hand[i]) begin
      repeat (gaps[i]) begin @(posedge clk); #1; obs_lat++; end
      set_in(sel, poke, 1'b1, hand[i]);
      @(posedge clk); #1; obs_lat++;
      set_in(sel, 1'b0, 1'b0, 4'd0);
    end
    obs_timeout = 1'b1;
    for (int k = 0; k < 40; k++) begin
      sample(sel);
      if (cur_done) begin obs_timeout = 1'b0; break; end
      @(posedge clk); #1; obs_lat++;
    end
    obs_is = cur_is; obs_max = cur_max; obs_bad = cur_bad; obs_busy_done = cur_busy;
    @(posedge clk); #1;
    sample(sel);
    obs_done_next = cur_done; obs_is_next = cur_is; obs_max_next = cur_max;
  endtask

  // Reference: highest fully-present window of run_len ranks; scan cycles = ranks from ace down to window base.
  task automatic ref_hand(input int run_len);
    bit pres[14];
    int lowest;
    bit ok;
    foreach (pres[r]) pres[r] = 1'b0;
    exp_bad = 1'b0;
    foreach (hand[i]) begin
      if (hand[i] >= 4'd14) exp_bad = 1'b1;
      else if (hand[i] == 4'd0) pres[13] = 1'b1;
      else pres[hand[i]] = 1'b1;
    end
    lowest = (WHEEL != 0) ? 0 : 1;
    pres[0] = pres[13];
    exp_is = 1'b0; exp_max = 0; exp_scan = 14 - lowest;
    for (int top = 13; top - run_len + 1 >= lowest; top--) begin
      ok = 1'b1;
      for (int r = top - run_len + 1; r <= top; r++) if (!pres[r]) ok = 1'b0;
      if (ok) begin
        exp_is = 1'b1; exp_max = top; exp_scan = 14 - (top - run_len + 1);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 4'd0);
    set_in(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_busy, a_done, a_is, a_max, a_bad} !== 8'd0) begin
      fails++; $display("FAIL reset_a outputs got=%b exp=0", {a_busy, a_done, a_is, a_max, a_bad});
    end
    checks++;
    if ({b_busy, b_done, b_is, b_max, b_bad} !== 8'd0) begin
      fails++; $display("FAIL reset_b outputs got=%b exp=0", {b_busy, b_done, b_is, b_max, b_bad});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_busy, a_done, a_is, a_max, a_bad} !== 8'd0) begin
      fails++; $display("FAIL idle_a outputs got=%b exp=0", {a_busy, a_done, a_is, a_max, a_bad});
    end
  endtask

  task automatic test_directed();
    logic [3:0] tbl[5][7];
    int e_is[5];
    int e_max[5];
    tbl = '{'{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd2, 4'd3},
            '{4'd0, 4'd1,  4'd2,  4'd3,  4'd4,  4'd8, 4'd10},
            '{4'd5, 4'd5,  4'd6,  4'd7,  4'd8,  4'd11, 4'd2},
            '{4'd3, 4'd4,  4'd5,  4'd6,  4'd7,  4'd8, 4'd9},
            '{4'd15, 4'd2, 4'd3,  4'd4,  4'd5,  4'd6, 4'd9}};
    e_is  = '{1, WHEEL, 0, 1, 1};
    e_max = '{13, (WHEEL != 0) ? 4 : 0, 0, 9, 6};
    for (int i = 0; i < 5; i++) begin
      hand = {}; gaps = {};
      for (int j = 0; j < 7; j++) begin hand.push_back(tbl[i][j]); gaps.push_back(0); end
      play(1'b0, 1'b0);
      ref_hand(5);
      checks++;
      if (obs_timeout || obs_is !== e_is[i][0]) begin
        fails++; $display("FAIL dir%0d is_straight got=%b exp=%0d timeout=%0b", i, obs_is, e_is[i], obs_timeout);
      end
      checks++;
      if (obs_max !== 4'(e_max[i])) begin
        fails++; $display("FAIL dir%0d max_num got=%0d exp=%0d", i, obs_max, e_max[i]);
      end
      checks++;
      if (obs_bad !== (i == 4)) begin
        fails++; $display("FAIL dir%0d bad_card got=%b exp=%0b", i, obs_bad, (i == 4));
      end
      checks++;
      if (obs_lat != 7 + exp_scan) begin
        fails++; $display("FAIL dir%0d latency got=%0d exp=%0d", i, obs_lat, 7 + exp_scan);
      end
      checks++;
      if (obs_done_next !== 1'b0 || obs_busy_load !== 1'b1 || obs_busy_done !== 1'b0) begin
        fails++; $display("FAIL dir%0d done_width/busy got done_next=%b busy_load=%b busy_done=%b exp=0/1/0",
                          i, obs_done_next, obs_busy_load, obs_busy_done);
      end
      checks++;
      if (obs_is_next !== e_is[i][0] || obs_max_next !== 4'(e_max[i])) begin
        fails++; $display("FAIL dir%0d hold got is=%b max=%0d exp is=%0d max=%0d", i, obs_is_next, obs_max_next, e_is[i], e_max[i]);
      end
    end
    checks++;
    if (obs_lat != 19) begin
      fails++; $display("FAIL dir_bad_latency got=%0d exp=19", obs_lat);
    end
  endtask

  task automatic test_small_run();
    hand = {4'd2, 4'd4, 4'd6, 4'd7, 4'd8};
    gaps = {0, 1, 0, 2, 0};
    play(1'b1, 1'b1);
    checks++;
    if (obs_timeout || obs_is !== 1'b1 || obs_max !== 4'd8) begin
      fails++; $display("FAIL small_dir got is=%b max=%0d exp is=1 max=8 timeout=%0b", obs_is, obs_max, obs_timeout);
    end
    checks++;
    if (obs_lat != 5 + 3 + 8 || obs_done_next !== 1'b0) begin
      fails++; $display("FAIL small_dir_latency got=%0d done_next=%b exp=16/0", obs_lat, obs_done_next);
    end
    for (int t = 0; t < 12; t++) begin
      hand = {}; gaps = {};
      for (int j = 0; j < 5; j++) begin
        hand.push_back(4'($urandom_range(0, 15)));
        gaps.push_back(int'($urandom_range(0, 1)));
      end
      play(1'b1, 1'($urandom_range(0, 1)));
      ref_hand(3);
      checks++;
      if (obs_timeout || obs_is !== exp_is || obs_max !== 4'(exp_max) || obs_bad !== exp_bad) begin
        fails++; $display("FAIL small_rand%0d got is=%b max=%0d bad=%b exp is=%0b max=%0d bad=%0b",
                          t, obs_is, obs_max, obs_bad, exp_is, exp_max, exp_bad);
      end
      checks++;
      if (obs_lat != 5 + gaps.sum() + exp_scan) begin
        fails++; $display("FAIL small_rand%0d latency got=%0d exp=%0d", t, obs_lat, 5 + gaps.sum() + exp_scan);
      end
    end
  endtask

  task automatic test_random();
    int base;
    logic [3:0] c;
    for (int t = 0; t < 30; t++) begin
      hand = {}; gaps = {};
      base = int'($urandom_range(1, 9));
      for (int j = 0; j < 7; j++) begin
        if (t % 2 == 0 && j < 5) c = 4'(base + j);
        else if ($urandom_range(0, 9) == 0) c = 4'($urandom_range(14, 15));
        else c = 4'($urandom_range(1, 13));
        if (c == 4'd13 && $urandom_range(0, 1) == 1) c = 4'd0;
        hand.push_back(c);
        gaps.push_back(int'($urandom_range(0, 2)));
      end
      play(1'b0, 1'($urandom_range(0, 1)));
      ref_hand(5);
      checks++;
      if (obs_timeout || obs_is !== exp_is || obs_max !== 4'(exp_max) || obs_bad !== exp_bad) begin
        fails++; $display("FAIL rand%0d got is=%b max=%0d bad=%b exp is=%0b max=%0d bad=%0b",
                          t, obs_is, obs_max, obs_bad, exp_is, exp_max, exp_bad);
      end
      checks++;
      if (obs_lat != 7 + gaps.sum() + exp_scan || obs_done_next !== 1'b0) begin
        fails++; $display("FAIL rand%0d latency got=%0d done_next=%b exp=%0d/0", t, obs_lat, obs_done_next, 7 + gaps.sum() + exp_scan);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    logic [3:0] cards[7];
    cards = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd2, 4'd3};
    set_in(1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    for (int j = 0; j < 7; j++) begin
      set_in(1'b0, 1'b0, 1'b1, cards[j]);
      @(posedge clk); #1;
    end
    set_in(1'b0, 1'b0, 1'b0, 4'd0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (a_busy !== 1'b1) begin
      fails++; $display("FAIL midscan_busy got=%b exp=1", a_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_done, a_is, a_max, a_bad} !== 8'd0) begin
      fails++; $display("FAIL midscan_reset outputs got=%b exp=0", {a_busy, a_done, a_is, a_max, a_bad});
    end
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (a_done || a_busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      fails++; $display("FAIL midscan_no_done got activity=1 exp=0");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_small_run();
    test_random();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/straight_scanner.md
STRAIGHT_SCANNER -- requirements
Module: straight_scanner

Interface
REQ-001 SHALL have parameter NUM_CARDS, default 7, number of cards per hand (legal range 5..15).
REQ-002 SHALL have parameter RUN_LEN, default 5, consecutive ranks that form a straight (legal range 2..13).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begins a new hand; sampled only in IDLE or DONE.
REQ-006 SHALL have port card_valid  input  1  qualifies card_number during LOAD.
REQ-007 SHALL have port card_number  input  4  rank code: 1=two .. 12=king, 13 or 0 = ace, 14..15 illegal.
REQ-008 SHALL have port busy  output  1  high in LOAD and SCAN.
REQ-009 SHALL have port done  output  1  single-cycle pulse when results become valid.
REQ-010 SHALL have port is_straight  output  1  a straight of RUN_LEN ranks exists.
REQ-011 SHALL have port max_num  output  4  top rank of the highest straight; 0 when none.
REQ-012 SHALL have port bad_card  output  1  sticky flag: an illegal code was loaded this hand.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> SCAN -> DONE -> (start) LOAD; DONE holds with no start.
REQ-014 SHALL, on start in IDLE/DONE, clear the 13-bit rank bitmap, card counter, is_straight, max_num, bad_card, and enter LOAD next cycle.
REQ-015 SHALL ignore start while busy is high.
REQ-016 SHALL in LOAD, per cycle with card_valid high, set bitmap bit for the rank (0 mapped to 13) and increment the card counter.
REQ-017 SHALL, for card codes 14/15, count the card, leave the bitmap unchanged, and set bad_card.
REQ-018 SHALL enter SCAN in the cycle after the NUM_CARDS-th accepted card; card_valid gaps stall LOAD indefinitely.
REQ-019 SHALL treat duplicate ranks as a single bitmap bit (duplicates never extend a run).
REQ-020 SHALL in SCAN examine one rank per cycle from 13 down to 1, run counter incremented on set bit, zeroed on clear bit.
REQ-021 SHALL, when run counter reaches RUN_LEN at rank r, set is_straight=1, max_num=r+RUN_LEN-1, and enter DONE next cycle (early exit).
REQ-022 SHALL enter DONE with is_straight=0, max_num=0 if no run completes after the last scanned rank.
REQ-023 SHALL therefore complete SCAN in at most 13 cycles (14 with wheel, REQ-028); max_num width 4 bits, no overflow since r+RUN_LEN-1 <= 13.
REQ-024 SHALL pulse done for exactly one cycle on DONE entry and hold is_straight, max_num, bad_card until the next accepted start.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force state IDLE, bitmap and counters 0, busy=0, done=0, is_straight=0, max_num=0, bad_card=0.
REQ-026 SHALL abandon any hand in progress on reset mid-LOAD or mid-SCAN, no done pulse issued.

Configuration
REQ-027 SHALL use macro STRAIGHT_WHEEL_EN to select ace-low straight support.
REQ-028 SHALL, with STRAIGHT_WHEEL_EN defined, scan one extra step after rank 1 using bitmap bit 13 as rank 0; a completing run there gives max_num=RUN_LEN-1 (4 for RUN_LEN=5).
REQ-029 SHALL, without STRAIGHT_WHEEL_EN, treat ace as high only; A-2-3-4-5 is not a straight.

Structure
REQ-030 SHALL place ACE_RANK=13, MIN_RANK=1, the rank-code width and the FSM state enum in shared package poker_pkg.
REQ-031 SHALL isolate the per-rank run counter and match logic in sub-module straight_run_scan; bitmap, loader and FSM stay in straight_scanner.

Verification
REQ-032 SHALL verify cards 9,10,11,12,13,2,3 (defaults) -> done after 7 load + 5 scan cycles, is_straight=1, max_num=13.
REQ-033 SHALL verify cards 0,1,2,3,4,8,10 with STRAIGHT_WHEEL_EN -> is_straight=1, max_num=4; without macro -> is_straight=0, max_num=0.
REQ-034 SHALL verify cards 5,5,6,7,8,11,2 -> is_straight=0, max_num=0 (duplicate not counted).
REQ-035 SHALL verify cards 3,4,5,6,7,8,9 -> max_num=9 (highest run chosen), done exactly one cycle wide.
REQ-036 SHALL verify card 15 among six others -> bad_card=1, still done after 7th card; rst_n low mid-SCAN -> all outputs 0, no done.
REQ-037 SHALL verify RUN_LEN=3, NUM_CARDS=5, cards 2,4,6,7,8 -> max_num=8; start during busy ignored.
